hand_gesture_decoder: RTL and testbench

Downstream stage of the per-frame colour-zone tracker. Once per frame it samples the winning blue and red zone indices, splits each into column and row, and filters out jitter with a per-hand stability counter. It then classifies settled hand movement into swipe gestures (left/right/up/down per hand) and reports each one as a single-cycle pulse to the command/UI logic.

---
 rtl/hand_gesture_decoder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_hand_gesture_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hand_gesture_decoder.sv
// hand_gesture_decoder
// Per-frame gesture classifier that sits after the colour-zone tracker.
// Once per frame it takes the winning blue and red zone indices and splits
// each one into a column and a row. A per-hand stability counter removes
// jitter. Movement of a settled hand away from its anchor becomes a swipe
// gesture, and each gesture is reported as a one-cycle pulse.
//
// Ports
//   pclk           clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   frame_done     one-cycle pulse, blue_flag/red_flag valid in this cycle
//   blue_flag      blue winning zone index (>= ZONES marks the hand invalid)
//   red_flag       red winning zone index (>= ZONES marks the hand invalid)
//   blue_col/row   last valid decomposed blue position
//   red_col/row    last valid decomposed red position
//   gesture        {hand (0 blue, 1 red), dir (0 L, 1 R, 2 U, 3 D)}
//   gesture_valid  one-cycle pulse qualifying gesture
//   busy           a frame is being processed
//   frame_drop     one-cycle pulse, a frame_done arrived while busy
module hand_gesture_decoder #(
    parameter int NX             = 10,
    parameter int NY             = 8,
    parameter int ZONES          = NX * NY,
    parameter int ZB             = $clog2(ZONES),
    parameter int CB             = $clog2(NX),
    parameter int RB             = $clog2(NY),
    parameter int STABLE_FRAMES  = 3,
    parameter int MOVE_TH        = 2,
    parameter int TIMEOUT_FRAMES = 30
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          frame_done,
    input  logic [ZB-1:0] blue_flag,
    input  logic [ZB-1:0] red_flag,
    output logic [CB-1:0] blue_col,
    output logic [RB-1:0] blue_row,
    output logic [CB-1:0] red_col,
    output logic [RB-1:0] red_row,
    output logic [2:0]    gesture,
    output logic          gesture_valid,
    output logic          busy,
    output logic          frame_drop
);

    localparam int NUM_LANES = 2;                      // lane 0 blue, lane 1 red
    localparam int DCW = (NY > 1) ? $clog2(NY) : 1;    // divide-step counter width
    localparam int SW  = $clog2(STABLE_FRAMES + 1);    // stability counter width
    localparam int AW  = $clog2(TIMEOUT_FRAMES + 1);   // anchor age width

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_FILTER,
        S_CLASSIFY,
        S_EMIT
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [DCW-1:0] r_div_cnt;
    logic [2:0]     r_gesture;
    logic           r_frame_drop;

    // Controls shared by both lanes.
    logic w_load;
    logic w_div_step;
    logic w_filter;
    logic w_classify;
    logic w_valid;
    logic [2:0] w_gesture;

    logic [NUM_LANES-1:0][ZB-1:0] w_flag;
    logic [NUM_LANES-1:0][CB-1:0] w_col;
    logic [NUM_LANES-1:0][RB-1:0] w_row;
    logic [NUM_LANES-1:0][1:0]    w_dir;
    logic [NUM_LANES-1:0]         w_pend;
    logic [NUM_LANES-1:0]         w_emit_clr;

    assign w_flag[0] = blue_flag;
    assign w_flag[1] = red_flag;

    // ------------------------------------------------------------------
    // FSM state register (also holds the divide counter, the last emitted
    // gesture and the registered drop pulse)
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_gesture    <= '0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_div_cnt    <= (r_state == S_DIV) ? r_div_cnt + DCW'(1) : '0;
            r_frame_drop <= frame_done && (r_state != S_IDLE);
            if (w_valid)
                r_gesture <= w_gesture;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (frame_done) w_next = S_DIV;
            S_DIV:      if (r_div_cnt == DCW'(NY - 1)) w_next = S_FILTER;
            S_FILTER:   w_next = S_CLASSIFY;
            S_CLASSIFY: w_next = S_EMIT;
            // A second EMIT cycle is needed only when both hands gestured.
            S_EMIT:     if (!(w_pend[0] && w_pend[1])) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs and lane controls
    // ------------------------------------------------------------------
    always_comb begin
        w_load     = (r_state == S_IDLE) && frame_done;
        w_div_step = (r_state == S_DIV);
        w_filter   = (r_state == S_FILTER);
        w_classify = (r_state == S_CLASSIFY);
        w_emit_clr = '0;
        w_valid    = 1'b0;
        w_gesture  = r_gesture;
        if (r_state == S_EMIT) begin
            // Blue is emitted before red.
            if (w_pend[0]) begin
                w_emit_clr[0] = 1'b1;
                w_valid       = 1'b1;
                w_gesture     = {1'b0, w_dir[0]};
            end else if (w_pend[1]) begin
                w_emit_clr[1] = 1'b1;
                w_valid       = 1'b1;
                w_gesture     = {1'b1, w_dir[1]};
            end
        end
        gesture       = w_gesture;
        gesture_valid = w_valid;
        busy          = (r_state != S_IDLE);
        frame_drop    = r_frame_drop;
    end

    assign blue_col = w_col[0];
    assign blue_row = w_row[0];
    assign red_col  = w_col[1];
    assign red_row  = w_row[1];

    // ------------------------------------------------------------------
    // Per-hand datapath: divider, stability filter, anchor and classifier
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_hand
        logic          r_valid;
        logic [ZB-1:0] r_rem;
        logic [RB-1:0] r_acc;
        logic [CB-1:0] r_pos_col, r_cand_col, r_anc_col;
        logic [RB-1:0] r_pos_row, r_cand_row, r_anc_row;
        logic [SW-1:0] r_cnt;
        logic          r_settled;
        logic          r_anc_valid;
        logic [AW-1:0] r_age;
        logic          r_pend;
        logic [1:0]    r_dir;

        logic [CB-1:0] w_pcol;
        logic [RB-1:0] w_prow;
        logic [CB:0]   w_dx, w_adx;
        logic [RB:0]   w_dy, w_ady;
        logic          w_gest;
        logic [1:0]    w_gdir;

        // After NY steps the remainder is below NX, so it fits in CB bits.
        assign w_pcol = r_rem[CB-1:0];
        assign w_prow = r_acc;

        // Signed displacement of the candidate from the anchor.
        always_comb begin
            w_dx   = {1'b0, r_cand_col} - {1'b0, r_anc_col};
            w_dy   = {1'b0, r_cand_row} - {1'b0, r_anc_row};
            w_adx  = w_dx[CB] ? -w_dx : w_dx;
            w_ady  = w_dy[RB] ? -w_dy : w_dy;
            w_gest = 1'b0;
            w_gdir = 2'd0;
            // Horizontal wins ties.
            if ((int'(w_adx) >= MOVE_TH) && (int'(w_adx) >= int'(w_ady))) begin
                w_gest = 1'b1;
                w_gdir = (!w_dx[CB] && (w_dx != '0)) ? 2'd1 : 2'd0;
            end else if (int'(w_ady) >= MOVE_TH) begin
                w_gest = 1'b1;
                w_gdir = (!w_dy[RB] && (w_dy != '0)) ? 2'd3 : 2'd2;
            end
        end

        always_ff @(posedge pclk) begin
            if (rst) begin
                r_valid     <= 1'b0;
                r_rem       <= '0;
                r_acc       <= '0;
                r_pos_col   <= '0;
                r_pos_row   <= '0;
                r_cand_col  <= '0;
                r_cand_row  <= '0;
                r_anc_col   <= '0;
                r_anc_row   <= '0;
                r_cnt       <= '0;
                r_settled   <= 1'b0;
                r_anc_valid <= 1'b0;
                r_age       <= '0;
                r_pend      <= 1'b0;
                r_dir       <= '0;
            end else begin
                if (w_load) begin
                    r_valid <= (int'(w_flag[g]) < ZONES);
                    r_rem   <= w_flag[g];
                    r_acc   <= '0;
                end

                // Restoring division by NX, one conditional subtract per cycle.
                if (w_div_step && (int'(r_rem) >= NX)) begin
                    r_rem <= r_rem - ZB'(NX);
                    r_acc <= r_acc + RB'(1);
                end

                if (w_filter) begin
                    if (r_valid) begin
                        r_pos_col <= w_pcol;
                        r_pos_row <= w_prow;
                        if ((w_pcol == r_cand_col) && (w_prow == r_cand_row)) begin
                            // Settling fires only on the step into saturation.
                            if (r_cnt != SW'(STABLE_FRAMES)) begin
                                r_cnt     <= r_cnt + SW'(1);
                                r_settled <= ((r_cnt + SW'(1)) == SW'(STABLE_FRAMES));
                            end else begin
                                r_settled <= 1'b0;
                            end
                        end else begin
                            r_cand_col <= w_pcol;
                            r_cand_row <= w_prow;
                            r_cnt      <= SW'(1);
                            r_settled  <= (STABLE_FRAMES == 1);
                        end
                    end else begin
                        r_cnt     <= '0;
                        r_settled <= 1'b0;
                    end
                end

                if (w_classify) begin
                    if (r_settled) begin
                        // A settled event takes priority over ageing.
                        if (!r_anc_valid) begin
                            r_anc_col   <= r_cand_col;
                            r_anc_row   <= r_cand_row;
                            r_anc_valid <= 1'b1;
                            r_age       <= '0;
                        end else if (w_gest) begin
                            r_pend    <= 1'b1;
                            r_dir     <= w_gdir;
                            r_anc_col <= r_cand_col;
                            r_anc_row <= r_cand_row;
                            r_age     <= '0;
                        end
                    end else if (r_anc_valid) begin
                        r_age <= r_age + AW'(1);
                        if ((r_age + AW'(1)) == AW'(TIMEOUT_FRAMES))
                            r_anc_valid <= 1'b0;
                    end
                end

                if (w_emit_clr[g])
                    r_pend <= 1'b0;
            end
        end

        assign w_col[g]  = r_pos_col;
        assign w_row[g]  = r_pos_row;
        assign w_pend[g] = r_pend;
        assign w_dir[g]  = r_dir;
    end

endmodule

// File: tb/tb_hand_gesture_decoder.sv
// Directed bench for hand_gesture_decoder with default parameters
// (10x8 zones, settle after 3 frames, threshold 2, timeout 30 frames).
module tb_hand_gesture_decoder;

    localparam logic [13:0] POS_DEC = {4'd7, 3'd3, 4'd9, 3'd7};  // 37 / 79

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_done = 1'b0;
    logic [6:0] blue_flag = '0;
    logic [6:0] red_flag = '0;
    logic [3:0] blue_col, red_col;
    logic [2:0] blue_row, red_row;
    logic [2:0] gesture;
    logic       gesture_valid, busy, frame_drop;

    int n_tests = 0;
    int n_fail = 0;

    // Per-frame capture, cycle offsets relative to the accepted frame_done.
    int          nv, c1, c2, busy_last, n_drop, drop_cyc, tot;
    logic        busy_t1;
    logic [2:0]  g1, g2;
    logic [13:0] pos9, pos10;

    always #5 pclk = ~pclk;

    hand_gesture_decoder dut (
        .pclk          (pclk),
        .rst           (rst),
        .frame_done    (frame_done),
        .blue_flag     (blue_flag),
        .red_flag      (red_flag),
        .blue_col      (blue_col),
        .blue_row      (blue_row),
        .red_col       (red_col),
        .red_row       (red_row),
        .gesture       (gesture),
        .gesture_valid (gesture_valid),
        .busy          (busy),
        .frame_drop    (frame_drop)
    );

    function automatic logic [13:0] cur_pos();
        return {blue_col, blue_row, red_col, red_row};
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    // Issue one frame and observe cycles T+1..T+14. If drop_at is nonzero,
    // a second frame_done is driven in cycle T+drop_at.
    task automatic run_frame(input logic [6:0] b, input logic [6:0] r, input int drop_at);
        blue_flag = b;
        red_flag = r;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        nv = 0; c1 = 0; c2 = 0; g1 = '0; g2 = '0;
        busy_last = 0; n_drop = 0; drop_cyc = 0;
        pos9 = '0; pos10 = '0;
        busy_t1 = busy;
        for (int c = 1; c <= 14; c++) begin
            frame_done = (c == drop_at);
            if (c == drop_at) begin
                blue_flag = '0;
                red_flag = '0;
            end
            if (gesture_valid) begin
                if (nv == 0) begin g1 = gesture; c1 = c; end
                else begin g2 = gesture; c2 = c; end
                nv++;
            end
            if (busy) busy_last = c;
            if (frame_drop) begin n_drop++; drop_cyc = c; end
            if (c == 9) pos9 = cur_pos();
            if (c == 10) pos10 = cur_pos();
            tick();
        end
        frame_done = 1'b0;
    endtask

    task automatic run_n(input logic [6:0] b, input logic [6:0] r, input int n);
        tot = 0;
        repeat (n) begin
            run_frame(b, r, 0);
            tot += nv;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++; if (cur_pos() !== 14'd0) begin n_fail++; $display("FAIL rst_pos: got %h want 0", cur_pos()); end
        n_tests++; if (gesture !== 3'd0) begin n_fail++; $display("FAIL rst_gesture: got %0d want 0", gesture); end
        n_tests++; if (gesture_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gv: got %b want 0", gesture_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_tests++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b want 0", frame_drop); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_decomp();
        run_frame(7'd37, 7'd79, 0);
        n_tests++; if (busy_t1 !== 1'b1) begin n_fail++; $display("FAIL dec_busy_t1: got %b want 1", busy_t1); end
        n_tests++; if (pos10 !== POS_DEC) begin n_fail++; $display("FAIL dec_pos: got %h want %h", pos10, POS_DEC); end
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL dec_nv: got %0d want 0", nv); end
        n_tests++; if (busy_last !== 11) begin n_fail++; $display("FAIL dec_busy_last: got %0d want 11", busy_last); end
        n_tests++; if (n_drop !== 0) begin n_fail++; $display("FAIL dec_drop: got %0d want 0", n_drop); end
    endtask

    task automatic test_reset_mid();
        blue_flag = 7'd22;
        red_flag = 7'd22;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        tick();                      // cycle T+3, inside DIV
        rst = 1'b1;
        repeat (3) tick();
        n_tests++; if (cur_pos() !== 14'd0) begin n_fail++; $display("FAIL mid_rst_pos: got %h want 0", cur_pos()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_tests++; if (gesture_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gv: got %b want 0", gesture_valid); end
        rst = 1'b0;
        tick();
        tick();
        run_frame(7'd37, 7'd79, 0);
        n_tests++; if (pos9 !== 14'd0) begin n_fail++; $display("FAIL mid_pos_t9: got %h want 0", pos9); end
        n_tests++; if (pos10 !== POS_DEC) begin n_fail++; $display("FAIL mid_pos_t10: got %h want %h", pos10, POS_DEC); end
    endtask

    task automatic test_swipe();
        run_n(7'd22, 7'd79, 3);      // anchor blue at (2,2)
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL sw_anchor: got %0d gestures want 0", tot); end
        run_n(7'd25, 7'd79, 2);
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL sw_pre: got %0d gestures want 0", tot); end
        run_frame(7'd25, 7'd79, 0);
        n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL sw_nv: got %0d want 1", nv); end
        n_tests++; if (g1 !== 3'b001) begin n_fail++; $display("FAIL sw_gesture: got %b want 001", g1); end
        n_tests++; if (c1 !== 11) begin n_fail++; $display("FAIL sw_latency: got %0d want 11", c1); end
        n_tests++; if (busy_last !== 11) begin n_fail++; $display("FAIL sw_busy_last: got %0d want 11", busy_last); end
        // Jitter 25,26,25 never settles.
        tot = 0;
        run_frame(7'd25, 7'd79, 0); tot += nv;
        run_frame(7'd26, 7'd79, 0); tot += nv;
        run_frame(7'd25, 7'd79, 0); tot += nv;
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL sw_jitter: got %0d gestures want 0", tot); end
        n_tests++; if ({blue_col, blue_row} !== {4'd5, 3'd2}) begin n_fail++; $display("FAIL sw_pos: got %h want 2a", {blue_col, blue_row}); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_n(7'd22, 7'd55, 3);      // anchors blue (2,2), red (5,5)
        run_n(7'd25, 7'd35, 2);
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL sim_pre: got %0d gestures want 0", tot); end
        run_frame(7'd25, 7'd35, 0);
        n_tests++; if (nv !== 2) begin n_fail++; $display("FAIL sim_nv: got %0d want 2", nv); end
        n_tests++; if (g1 !== 3'b001 || c1 !== 11) begin n_fail++; $display("FAIL sim_first: got %b@%0d want 001@11", g1, c1); end
        n_tests++; if (g2 !== 3'b110 || c2 !== 12) begin n_fail++; $display("FAIL sim_second: got %b@%0d want 110@12", g2, c2); end
        n_tests++; if (busy_last !== 12) begin n_fail++; $display("FAIL sim_busy_last: got %0d want 12", busy_last); end
        n_tests++; if (gesture !== 3'b110 || gesture_valid !== 1'b0) begin n_fail++; $display("FAIL sim_hold: got %b/%b want 110/0", gesture, gesture_valid); end
    endtask

    task automatic test_timeout();
        do_reset();                  // red held invalid (90) throughout
        run_n(7'd22, 7'd90, 3);      // anchor (2,2), age 0
        run_n(7'd23, 7'd90, 3);      // dx=1 settles: no gesture, age 2
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL to_small_dx: got %0d gestures want 0", tot); end
        // If 23 had replaced the anchor, 24 (dx=1) would not gesture.
        run_n(7'd24, 7'd90, 2);
        run_frame(7'd24, 7'd90, 0);
        n_tests++; if (nv !== 1 || g1 !== 3'b001) begin n_fail++; $display("FAIL to_anchor_kept: got %0d/%b want 1/001", nv, g1); end
        // Anchor (4,2): 29 non-settling frames, still alive at the settle.
        run_n(7'd24, 7'd90, 27);
        run_n(7'd27, 7'd90, 2);
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL to_idle29: got %0d gestures want 0", tot); end
        run_frame(7'd27, 7'd90, 0);
        n_tests++; if (nv !== 1 || g1 !== 3'b001) begin n_fail++; $display("FAIL to_age29: got %0d/%b want 1/001", nv, g1); end
        // Anchor (7,2): age reaches 30 before the next settle, so it expires.
        run_n(7'd27, 7'd90, 28);
        run_n(7'd22, 7'd90, 2);
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL to_idle30: got %0d gestures want 0", tot); end
        run_frame(7'd22, 7'd90, 0);
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL to_expired: got %0d gestures want 0", nv); end
        // The new anchor is (2,2).
        run_n(7'd25, 7'd90, 2);
        run_frame(7'd25, 7'd90, 0);
        n_tests++; if (nv !== 1 || g1 !== 3'b001) begin n_fail++; $display("FAIL to_new_anchor: got %0d/%b want 1/001", nv, g1); end
    endtask

    task automatic test_robust();
        // Blue is anchored at (5,2). Two frames at 28, then an invalid frame.
        run_n(7'd28, 7'd90, 2);
        run_frame(7'd90, 7'd90, 0);
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL rb_invalid_nv: got %0d want 0", nv); end
        n_tests++; if ({blue_col, blue_row} !== {4'd8, 3'd2}) begin n_fail++; $display("FAIL rb_hold: got %h want 42", {blue_col, blue_row}); end
        // The counter restarted, so the third valid frame settles.
        run_n(7'd28, 7'd90, 2);
        n_tests++; if (tot !== 0) begin n_fail++; $display("FAIL rb_cnt_cleared: got %0d gestures want 0", tot); end
        run_frame(7'd28, 7'd90, 0);
        n_tests++; if (nv !== 1 || g1 !== 3'b001) begin n_fail++; $display("FAIL rb_resettle: got %0d/%b want 1/001", nv, g1); end
        // frame_done at T+4 is dropped.
        run_frame(7'd37, 7'd79, 4);
        n_tests++; if (n_drop !== 1 || drop_cyc !== 5) begin n_fail++; $display("FAIL rb_drop: got %0d@%0d want 1@5", n_drop, drop_cyc); end
        n_tests++; if (pos10 !== POS_DEC) begin n_fail++; $display("FAIL rb_drop_pos: got %h want %h", pos10, POS_DEC); end
        n_tests++; if (busy_last !== 11) begin n_fail++; $display("FAIL rb_drop_busy: got %0d want 11", busy_last); end
    endtask

    initial begin
        test_reset();
        test_decomp();
        test_reset_mid();
        test_swipe();
        test_simultaneous();
        test_timeout();
        test_robust();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
